// File: rtl/aes_inv_top.sv
// AES-128 iterative inverse cipher: the forward key schedule runs up to K10,
// then one decryption round per cycle walks the schedule back down to K0.

package aes_inv_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

  // Inverse taken as a^254 (product of a^2 .. a^128); zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

module aes_sbox
  import aes_inv_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);
  logic [7:0] inv_s;

  // Field inverse followed by the forward affine transform.
  always_comb begin
    inv_s  = gf_inv(value);
    result = inv_s ^ rotl8(inv_s, 1) ^ rotl8(inv_s, 2) ^ rotl8(inv_s, 3)
           ^ rotl8(inv_s, 4) ^ 8'h63;
  end
endmodule

module aes_inv_sbox
  import aes_inv_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);
  logic [7:0] pre_s;

  // Inverse affine transform followed by the field inverse.
  always_comb begin
    pre_s  = rotl8(value, 1) ^ rotl8(value, 3) ^ rotl8(value, 6) ^ 8'h05;
    result = gf_inv(pre_s);
  end
endmodule

module aes_inv_top
  import aes_inv_pkg::*;
(
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic         AES_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    DEC    = 2'd2
  } fsm_t;

  fsm_t         fsm_r;
  logic [127:0] state_r;
  logic [127:0] key_r;
  logic [3:0]   round_r;

  logic [31:0]  kw0_s, kw1_s, kw2_s, kw3_s;
  logic [31:0]  ks_word_s;
  logic [31:0]  ks_rot_s;
  logic [31:0]  ks_sub_s;
  logic [31:0]  ks_t_s;
  logic [7:0]   rcon_s;
  logic [127:0] key_fwd_s;
  logic [127:0] key_inv_s;

  logic [127:0] isr_s;
  logic [127:0] isb_s;
  logic [127:0] ark_s;
  logic [127:0] imc_s;

  // The S-box word is w3 going forward; going backward w3 is first recovered as n3 ^ n2.
  always_comb begin
    kw0_s = key_r[127:96];
    kw1_s = key_r[95:64];
    kw2_s = key_r[63:32];
    kw3_s = key_r[31:0];
    if (fsm_r == DEC) begin
      ks_word_s = kw3_s ^ kw2_s;
    end else begin
      ks_word_s = kw3_s;
    end
    ks_rot_s = {ks_word_s[23:0], ks_word_s[31:24]};
    rcon_s   = rcon(round_r);
  end

  genvar g;
  for (g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (
      .value  (ks_rot_s[8*g +: 8]),
      .result (ks_sub_s[8*g +: 8])
    );
  end

  // One forward and one inverse key-schedule step, both from key_r and the round count.
  always_comb begin
    ks_t_s = ks_sub_s ^ {rcon_s, 24'h000000};
    key_fwd_s[127:96] = kw0_s ^ ks_t_s;
    key_fwd_s[95:64]  = kw1_s ^ kw0_s ^ ks_t_s;
    key_fwd_s[63:32]  = kw2_s ^ kw1_s ^ kw0_s ^ ks_t_s;
    key_fwd_s[31:0]   = kw3_s ^ kw2_s ^ kw1_s ^ kw0_s ^ ks_t_s;
    key_inv_s[127:96] = kw0_s ^ ks_t_s;
    key_inv_s[95:64]  = kw1_s ^ kw0_s;
    key_inv_s[63:32]  = kw2_s ^ kw1_s;
    key_inv_s[31:0]   = kw3_s ^ kw2_s;
  end

  // Row r of the column-major state rotates right by r columns.
  always_comb begin
    isr_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr_s[127 - 8*(r + 4*c) -: 8] = state_r[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
  end

  for (g = 0; g < 16; g++) begin : g_state_sbox
    aes_inv_sbox u_inv_sbox (
      .value  (isr_s[8*g +: 8]),
      .result (isb_s[8*g +: 8])
    );
  end

  // Round key add and column mixing for the full decryption rounds.
  always_comb begin
    ark_s = isb_s ^ key_inv_s;
    imc_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      imc_s[127 - 32*c -: 32] = inv_mix_col(ark_s[127 - 32*c -: 32]);
    end
  end

  // Control sequence, datapath registers and registered outputs.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      fsm_r              <= IDLE;
      state_r            <= 128'h0;
      key_r              <= 128'h0;
      round_r            <= 4'd0;
      AES_data_out       <= 128'h0;
      AES_data_out_valid <= 1'b0;
      AES_busy           <= 1'b0;
    end else begin
      AES_data_out_valid <= 1'b0;
      case (fsm_r)
        IDLE: begin
          if (AES_en) begin
            state_r  <= AES_data_in;
            key_r    <= AES_key_in;
            round_r  <= 4'd1;
            AES_busy <= 1'b1;
            fsm_r    <= KEYEXP;
          end else begin
            AES_busy <= 1'b0;
          end
        end
        KEYEXP: begin
          key_r <= key_fwd_s;
          if (round_r == 4'd10) begin
            state_r <= state_r ^ key_fwd_s;
            fsm_r   <= DEC;
          end else begin
            round_r <= round_r + 4'd1;
          end
        end
        DEC: begin
          key_r <= key_inv_s;
          if (round_r == 4'd1) begin
            AES_data_out       <= ark_s;
            AES_data_out_valid <= 1'b1;
            AES_busy           <= 1'b0;
            round_r            <= 4'd0;
            fsm_r              <= IDLE;
          end else begin
            state_r <= imc_s;
            round_r <= round_r - 4'd1;
          end
        end
        default: begin
          fsm_r    <= IDLE;
          round_r  <= 4'd0;
          AES_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_top.sv
// Scoreboard bench for aes_inv_top: FIPS-197 vectors, busy/reset behaviour and
// random round trips against a table-driven AES-128 encryption model.

module tb_aes_inv_top;

  logic         AES_clk = 1'b0;
  logic         AES_rst;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;
  logic         AES_busy;

  aes_inv_top dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid),
    .AES_busy           (AES_busy)
  );

  always #5 AES_clk = ~AES_clk;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  int cyc = 0;
  always @(posedge AES_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  bit prev_valid = 1'b0;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } sb_item_t;
  sb_item_t sb_q[$];
  sb_item_t mon_item;

  // ---------------- reference model ----------------
  bit [7:0]   sbox_t[256];
  bit [7:0]   alog_t[256];
  int         log_t[256];
  bit [127:0] rk_t[11];

  function automatic bit [7:0] rot8(bit [7:0] a, int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-box generated by walking powers of 3 and their inverses together.
  function automatic void build_tables();
    bit [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog_t[i] = p;
      log_t[p]  = i;
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endfunction

  function automatic bit [7:0] gm(bit [7:0] a, bit [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return alog_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  function automatic bit [7:0] getb(bit [127:0] x, int k);
    return x[127 - 8*k -: 8];
  endfunction

  function automatic bit [127:0] setb(bit [127:0] x, int k, bit [7:0] v);
    x[127 - 8*k -: 8] = v;
    return x;
  endfunction

  function automatic void expand_key(bit [127:0] key);
    bit [31:0] w[44];
    bit [31:0] t;
    bit [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_t[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic bit [127:0] encrypt(bit [127:0] key, bit [127:0] pt);
    bit [127:0] s, y;
    bit [7:0]   cf[4];
    bit [7:0]   v;
    cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    expand_key(key);
    s = pt ^ rk_t[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s = setb(s, k, sbox_t[getb(s, k)]);
      y = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          y = setb(y, r + 4*c, getb(s, r + 4*((c + r) % 4)));
      s = y;
      if (rnd < 10) begin
        y = '0;
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            v = 8'h00;
            for (int j = 0; j < 4; j++) v = v ^ gm(cf[(j - row + 4) % 4], getb(s, j + 4*c));
            y = setb(y, row + 4*c, v);
          end
        s = y;
      end
      s = s ^ rk_t[rnd];
    end
    return s;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge AES_clk) begin
    if (AES_data_out_valid === 1'b1) begin
      valid_seen++;
      check("valid_single", prev_valid, 1'b0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid with no block outstanding, out=%h cyc=%0d",
                 AES_data_out, cyc);
      end else begin
        mon_item = sb_q.pop_front();
        check("data", AES_data_out, mon_item.data);
        check("latency", cyc - mon_item.acc, 20);
      end
    end
    prev_valid = (AES_data_out_valid === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic expect_block(input logic [127:0] pt, input int acc);
    sb_item_t e;
    e.data = pt;
    e.acc  = acc;
    sb_q.push_back(e);
  endtask

  task automatic start(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
    AES_key_in  = key;
    AES_data_in = ct;
    AES_en      = 1'b1;
    expect_block(pt, cyc + 1);
  endtask

  task automatic drain(input bit scramble);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      if (scramble) begin
        AES_data_in = rand128();
        AES_key_in  = rand128();
        AES_en      = (n < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      tick();
      n++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int vs;
    int acc1;
    bit idle_bad;
    logic [127:0] k, p, c;

    build_tables();
    AES_rst = 1'b1;
    AES_en = 1'b0;
    AES_data_in = '0;
    AES_key_in = '0;
    tick();
    tick();
    check("reset_out", AES_data_out, 128'h0);
    check("reset_valid", AES_data_out_valid, 1'b0);
    check("reset_busy", AES_busy, 1'b0);
    AES_rst = 1'b0;

    // idle with enable low
    vs = valid_seen;
    idle_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      AES_data_in = rand128();
      AES_key_in = rand128();
      tick();
      if (AES_busy !== 1'b0 || AES_data_out !== 128'h0) idle_bad = 1'b1;
    end
    check("idle_valid_count", valid_seen - vs, 0);
    check("idle_busy_out", idle_bad, 1'b0);

    // reset wins over enable in IDLE, then enable starts at the first free edge
    AES_data_in = C1_CT;
    AES_key_in = C1_KEY;
    AES_rst = 1'b1;
    AES_en = 1'b1;
    tick();
    check("rst_priority_busy", AES_busy, 1'b0);
    AES_rst = 1'b0;
    expect_block(C1_PT, cyc + 1);
    tick();
    AES_en = 1'b0;
    drain(0);

    // C.1 with busy/valid profile
    start(C1_KEY, C1_CT, C1_PT);
    tick();
    AES_en = 1'b0;
    check("busy_e0", AES_busy, 1'b1);
    repeat (19) tick();
    check("busy_e19", AES_busy, 1'b1);
    check("valid_e19", AES_data_out_valid, 1'b0);
    tick();
    check("busy_e20", AES_busy, 1'b0);
    check("valid_e20", AES_data_out_valid, 1'b1);
    tick();
    check("valid_e21", AES_data_out_valid, 1'b0);
    check("hold_e21", AES_data_out, C1_PT);
    drain(0);

    // App. B with inputs scrambled while busy
    start(B_KEY, B_CT, B_PT);
    tick();
    AES_en = 1'b0;
    drain(1);
    check("hold_after_b", AES_data_out, B_PT);

    // busy-ignore with enable held: second block accepted at E21
    acc1 = cyc + 1;
    start(C1_KEY, C1_CT, C1_PT);
    tick();
    repeat (5) tick();
    AES_data_in = B_CT;
    AES_key_in = B_KEY;
    expect_block(B_PT, acc1 + 21);
    repeat (16) tick();
    AES_en = 1'b0;
    drain(0);

    // reset abort at E12, restart with enable held through reset
    start(C1_KEY, C1_CT, C1_PT);
    tick();
    AES_en = 1'b0;
    repeat (11) tick();
    AES_rst = 1'b1;
    AES_en = 1'b1;
    sb_q.delete();
    tick();
    check("abort_out", AES_data_out, 128'h0);
    check("abort_busy", AES_busy, 1'b0);
    check("abort_valid", AES_data_out_valid, 1'b0);
    AES_rst = 1'b0;
    expect_block(C1_PT, cyc + 1);
    tick();
    AES_en = 1'b0;
    check("busy_restart", AES_busy, 1'b1);
    drain(0);

    // random round trips
    for (int i = 0; i < 500; i++) begin
      k = rand128();
      p = rand128();
      c = encrypt(k, p);
      start(k, c, p);
      tick();
      AES_en = 1'b0;
      drain(1);
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
